alu_share_arbiter: RTL

- Shares one registered 4-bit ALU (opcodes 001 AND, 010 ADD, 011 NOR, 100 SUB; 000 = hold previous result/CF) between NUM_REQ requesters.
- Round-robin arbitration.
- Issues one operation at a time and returns the result and flags to the granted requester.
- Sits between requester logic and the ALU. The block owns the ALU's A/B/opcode inputs and drives opcode 000 whenever idle, so ALU state is preserved between operations.

---
 rtl/alu_share_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit ALU among NUM_REQ requesters.
// Define ALU_ARB_OPCHECK_EN to block opcodes 101/110/111 and answer them with rsp_err.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [3:0]           rsp_c,
  output logic                 rsp_cf,
  output logic                 rsp_zf,
  output logic                 rsp_sf,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_opcode,
  input  logic [3:0]           alu_c,
  input  logic                 alu_cf,
  input  logic                 alu_zf,
  input  logic                 alu_sf
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [3:0]         a_q, a_d;
  logic [3:0]         b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [3:0]         c_q, c_d;
  logic               cf_q, cf_d;
  logic               zf_q, zf_d;
  logic               sf_q, sf_d;
  logic               err_q, err_d;
  logic               ill_q, ill_d;
  logic               busy_q, busy_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;
  logic [3:0]         sel_a;
  logic [3:0]         sel_b;
  logic [2:0]         sel_op;
  logic               sel_ill;
  logic [IDX_W-1:0]   gnt_inc;

  // Scan downward so the lowest rotation offset from rr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_a  = req_a[4*i +: 4];
        sel_b  = req_b[4*i +: 4];
        sel_op = req_op[3*i +: 3];
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign sel_ill = sel_op[2] & (sel_op[1] | sel_op[0]);
`else
  assign sel_ill = 1'b0;
`endif

  assign gnt_inc = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    done_d  = '0;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = 3'b000;
    c_d     = c_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    err_d   = err_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ISSUE;
          gnt_d   = pick_idx;
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_ill ? 3'b000 : sel_op;
          ill_d   = sel_ill;
          ack_d   = NUM_REQ'(1) << pick_idx;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        rr_d    = gnt_inc;
      end
      WAIT: begin
        state_d = RESP;
        done_d  = NUM_REQ'(1) << gnt_q;
        if (ill_q) begin
          c_d   = '0;
          cf_d  = 1'b0;
          zf_d  = 1'b0;
          sf_d  = 1'b0;
          err_d = 1'b1;
        end else begin
          c_d   = alu_c;
          cf_d  = alu_cf;
          zf_d  = alu_zf;
          sf_d  = alu_sf;
          err_d = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      c_q     <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      c_q     <= c_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
      busy_q  <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign rsp_c      = c_q;
  assign rsp_cf     = cf_q;
  assign rsp_zf     = zf_q;
  assign rsp_sf     = sf_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;

endmodule
